// File: rtl/dmem_access_ctrl.sv
// Memory-stage access sequencer: issues one data-memory transaction per MA-stage load/store,
// stalls the front of the pipeline while it is outstanding and returns extended load data.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_valid,
    input  logic        M_mem_rd,
    input  logic        M_mem_we,
    input  logic [2:0]  M_funct3,
    input  logic [31:0] M_alu_o,
    input  logic [31:0] M_wd,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        W_bubble,
    output logic [31:0] M_dm_rd,
    output logic        err_access,
    output logic        err_timeout,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_lo;
    logic        mem_op;
    logic        illegal;
    logic        issue;
    logic        timeout_hit;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    assign mem_op = M_valid & (M_mem_rd | M_mem_we);

    always_comb begin
        illegal = 1'b0;
        if (M_mem_we)
            illegal = (M_funct3 > 3'b010);
        else
            illegal = (M_funct3 == 3'b011) | (M_funct3[2:1] == 2'b11);
        if (M_funct3[1:0] == 2'b01 && M_alu_o[0])
            illegal = 1'b1;
        if (M_funct3[1:0] == 2'b10 && M_alu_o[1:0] != 2'b00)
            illegal = 1'b1;
    end

    assign issue       = (state == IDLE) & mem_op & ~illegal;
    // Reset forces the pipeline free even while the MA stage still shows a memory op.
    assign stall       = rst & (issue | (state == ACCESS));
    assign W_bubble    = stall;
    assign err_access  = rst & (state == IDLE) & mem_op & illegal;
    assign timeout_hit = (cnt + 8'd1) == TIMEOUT_LIMIT;
    assign dbg_state   = state;

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = M_wd;
        if (M_mem_we) begin
            case (M_funct3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << M_alu_o[1:0];
                    wdata_n = {4{M_wd[7:0]}};
                end
                2'b01: begin
                    be_n    = M_alu_o[1] ? 4'b1100 : 4'b0011;
                    wdata_n = {2{M_wd[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = M_wd;
                end
            endcase
        end
    end

    always_comb begin
        case (ld_lo)
            2'd0:    rd_byte = dm_rdata[7:0];
            2'd1:    rd_byte = dm_rdata[15:8];
            2'd2:    rd_byte = dm_rdata[23:16];
            default: rd_byte = dm_rdata[31:24];
        endcase
        rd_half = ld_lo[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'd0, rd_byte};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    // Handshake: dm_req rises with dm_we/dm_addr/dm_wdata/dm_be already stable and all of them
    // hold until the cycle dm_ack is seen (dm_rdata valid that same cycle) or the timeout fires;
    // dm_ack is ignored in any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            ld_f3       <= 3'd0;
            ld_lo       <= 2'd0;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= 32'd0;
            dm_wdata    <= 32'd0;
            dm_be       <= 4'd0;
            M_dm_rd     <= 32'd0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    err_timeout <= 1'b0;
                    if (issue) begin
                        dm_req   <= 1'b1;
                        dm_we    <= M_mem_we;
                        dm_addr  <= {M_alu_o[31:2], 2'b00};
                        dm_wdata <= wdata_n;
                        dm_be    <= be_n;
                        ld_f3    <= M_funct3;
                        ld_lo    <= M_alu_o[1:0];
                        cnt      <= 8'd0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dm_ack) begin
                        dm_req  <= 1'b0;
                        M_dm_rd <= dm_we ? 32'd0 : ld_ext;
                        state   <= DONE;
                    end else if (timeout_hit) begin
                        dm_req      <= 1'b0;
                        err_timeout <= 1'b1;
                        M_dm_rd     <= 32'd0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    err_timeout <= 1'b0;
                    M_dm_rd     <= 32'd0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: drivers push expected completions, a negedge monitor
// pops and compares them whenever the DUT reaches DONE or flags an access error.
module tb_dmem_access_ctrl;

  localparam int W = 119;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic        clk;
  logic        rst;
  logic        M_valid;
  logic        M_mem_rd;
  logic        M_mem_we;
  logic [2:0]  M_funct3;
  logic [31:0] M_alu_o;
  logic [31:0] M_wd;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic        W_bubble;
  logic [31:0] M_dm_rd;
  logic        err_access;
  logic        err_timeout;
  logic [1:0]  dbg_state;

  int checks;
  int failures;
  int stall_run;
  int req_run;

  logic [W-1:0] exp_q[$];

  logic        prev_req;
  logic        prev_we;
  logic [3:0]  prev_be;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .M_valid(M_valid),
    .M_mem_rd(M_mem_rd),
    .M_mem_we(M_mem_we),
    .M_funct3(M_funct3),
    .M_alu_o(M_alu_o),
    .M_wd(M_wd),
    .dm_req(dm_req),
    .dm_we(dm_we),
    .dm_addr(dm_addr),
    .dm_wdata(dm_wdata),
    .dm_be(dm_be),
    .dm_ack(dm_ack),
    .dm_rdata(dm_rdata),
    .stall(stall),
    .W_bubble(W_bubble),
    .M_dm_rd(M_dm_rd),
    .err_access(err_access),
    .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic mem_access(input logic is_st, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input int a_cycles, input logic ack,
                            input logic [31:0] rdata, input logic [31:0] exp_rd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    exp_q.push_back({1'b0, ~ack, is_st, exp_be, exp_addr, exp_wdata, exp_rd,
                     8'(a_cycles + 1), 8'(a_cycles)});
    @(posedge clk); #1;
    M_valid  = 1'b1;
    M_mem_rd = ~is_st;
    M_mem_we = is_st;
    M_funct3 = f3;
    M_alu_o  = addr;
    M_wd     = wd;
    for (int i = 0; i < a_cycles; i++) begin
      @(posedge clk); #1;
      dm_ack   = ack && (i == a_cycles - 1);
      dm_rdata = dm_ack ? rdata : 32'h5A5A_5A5A;
    end
    @(posedge clk); #1;
    dm_ack   = 1'b0;
    dm_rdata = 32'h5A5A_5A5A;
    M_valid  = 1'b0;
    M_mem_rd = 1'b0;
    M_mem_we = 1'b0;
  endtask

  task automatic bad_access(input logic is_st, input logic [2:0] f3, input logic [31:0] addr);
    exp_q.push_back({1'b1, 1'b0, is_st, 4'd0, 32'd0, 32'd0, 32'd0, 8'd0, 8'd0});
    @(posedge clk); #1;
    M_valid  = 1'b1;
    M_mem_rd = ~is_st;
    M_mem_we = is_st;
    M_funct3 = f3;
    M_alu_o  = addr;
    M_wd     = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    M_valid  = 1'b0;
    M_mem_rd = 1'b0;
    M_mem_we = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic        x_ea, x_et, x_we;
    logic [3:0]  x_be;
    logic [31:0] x_addr, x_wd, x_rd;
    logic [7:0]  x_st, x_rq;
    if (!rst) begin
      stall_run = 0;
      req_run   = 0;
      prev_req  = 1'b0;
    end else begin
      if (stall) stall_run++;
      if (dm_req) req_run++;
      if (dm_req && prev_req) begin
        check("req_hold_addr", dm_addr, prev_addr);
        check("req_hold_wdata", dm_wdata, prev_wdata);
        check("req_hold_be_we", {27'd0, dm_we, dm_be}, {27'd0, prev_we, prev_be});
      end
      prev_req   = dm_req;
      prev_we    = dm_we;
      prev_be    = dm_be;
      prev_addr  = dm_addr;
      prev_wdata = dm_wdata;
      if (err_timeout && dbg_state != ST_DONE)
        check("err_timeout_outside_done", {31'd0, err_timeout}, 32'd0);
      if (err_access || dbg_state == ST_DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          {x_ea, x_et, x_we, x_be, x_addr, x_wd, x_rd, x_st, x_rq} = e;
          check("err_access", {31'd0, err_access}, {31'd0, x_ea});
          check("err_timeout", {31'd0, err_timeout}, {31'd0, x_et});
          check("M_dm_rd", M_dm_rd, x_rd);
          check("stall_now", {31'd0, stall}, 32'd0);
          check("W_bubble_eq_stall", {31'd0, W_bubble}, {31'd0, stall});
          check("stall_cycles", 32'(stall_run), {24'd0, x_st});
          check("req_cycles", 32'(req_run), {24'd0, x_rq});
          if (!x_ea) begin
            check("dm_we", {31'd0, dm_we}, {31'd0, x_we});
            check("dm_be", {28'd0, dm_be}, {28'd0, x_be});
            check("dm_addr", dm_addr, x_addr);
            if (x_we) check("dm_wdata", dm_wdata, x_wd);
          end else begin
            check("dm_req_on_err", {31'd0, dm_req}, 32'd0);
          end
          stall_run = 0;
          req_run   = 0;
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    stall_run = 0;
    req_run   = 0;
    prev_req  = 1'b0;
    rst       = 1'b0;
    M_valid   = 1'b0;
    M_mem_rd  = 1'b0;
    M_mem_we  = 1'b0;
    M_funct3  = 3'd0;
    M_alu_o   = 32'd0;
    M_wd      = 32'd0;
    dm_ack    = 1'b0;
    dm_rdata  = 32'h5A5A_5A5A;
    #2;
    check("rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("rst_dm_we", {31'd0, dm_we}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_errs", {30'd0, err_access, err_timeout}, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_dm_be", {28'd0, dm_be}, 32'd0);
    check("rst_M_dm_rd", M_dm_rd, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // is_st f3 addr wd a_cycles ack rdata exp_rd exp_be exp_wdata
    mem_access(1'b0, 3'b010, 32'h100, 32'd0, 1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 32'd0);
    mem_access(1'b0, 3'b000, 32'h103, 32'd0, 1, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80, 4'b1111, 32'd0);
    mem_access(1'b0, 3'b100, 32'h103, 32'd0, 1, 1'b1, 32'h80FF_0000, 32'h0000_0080, 4'b1111, 32'd0);
    mem_access(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 4, 1'b1, 32'h5555_5555, 32'd0, 4'b1100, 32'hABCD_ABCD);
    bad_access(1'b0, 3'b010, 32'h101);
    mem_access(1'b0, 3'b010, 32'h104, 32'd0, 4, 1'b0, 32'd0, 32'd0, 4'b1111, 32'd0);
    mem_access(1'b0, 3'b001, 32'h106, 32'd0, 4, 1'b1, 32'h8001_0000, 32'hFFFF_8001, 4'b1111, 32'd0);
    mem_access(1'b0, 3'b101, 32'h100, 32'd0, 2, 1'b1, 32'h1234_F00D, 32'h0000_F00D, 4'b1111, 32'd0);
    mem_access(1'b1, 3'b000, 32'h301, 32'h0000_00A5, 1, 1'b1, 32'd0, 32'd0, 4'b0010, 32'hA5A5_A5A5);
    bad_access(1'b0, 3'b011, 32'h100);
    bad_access(1'b1, 3'b100, 32'h100);
    bad_access(1'b1, 3'b001, 32'h203);
    mem_access(1'b0, 3'b000, 32'h102, 32'd0, 1, 1'b1, 32'h007F_0000, 32'h0000_007F, 4'b1111, 32'd0);

    // reset pulled low during the second ACCESS cycle of a load
    @(posedge clk); #1;
    M_valid  = 1'b1;
    M_mem_rd = 1'b1;
    M_funct3 = 3'b010;
    M_alu_o  = 32'h108;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid_access_req_before_rst", {31'd0, dm_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    check("async_rst_state", {30'd0, dbg_state}, 32'd0);
    M_valid  = 1'b0;
    M_mem_rd = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    mem_access(1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 2, 1'b1, 32'd0, 32'd0, 4'b1111, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage access sequencer for the pipelined core. Handles a multi-cycle data-memory handshake on behalf of the MA stage, stalls the front of the pipeline while an access is outstanding, and feeds bubbles into the MA/WB pipeline register. When the access completes, it delivers size- and sign-extended load data on `M_dm_rd` for capture into the MA/WB register.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of ACCESS-state cycles without `dm_ack`. Legal range is 1..255; the counter is 8 bits.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `M_valid` in 1: the MA stage holds a valid instruction.
- `M_mem_rd` in 1: the MA instruction is a load.
- `M_mem_we` in 1: the MA instruction is a store. Never high together with `M_mem_rd`.
- `M_funct3` in 3: access size and signedness.
- `M_alu_o` in 32: byte address.
- `M_wd` in 32: store data.
- `dm_req` out 1: memory request.
- `dm_we` out 1: write request.
- `dm_addr` out 32: word address, equal to `{M_alu_o[31:2], 2'b00}`.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_be` out 4: byte enables.
- `dm_ack` in 1: memory completion; `dm_rdata` is valid in the same cycle.
- `dm_rdata` in 32: raw read word.
- `stall` out 1: freezes the PC, IF/ID, ID/EX and EX/MA registers.
- `W_bubble` out 1: forces `W_we_rf` to 0 on MA/WB capture. Always equals `stall`.
- `M_dm_rd` out 32: extended load data to the MA/WB register.
- `err_access` out 1: one-cycle pulse for a misaligned access or illegal `M_funct3`.
- `err_timeout` out 1: one-cycle pulse when the access times out.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- Reset values: `dm_req`, `dm_we`, `stall`, `err_*` are 0; `dm_addr`, `dm_wdata`, `dm_be`, `M_dm_rd` are 0.
- Memory op detection: `M_valid & (M_mem_rd | M_mem_we)`.
- IDLE, memory op and legal:
  - `stall` = 1 combinationally.
  - Register `dm_addr`, `dm_we`, `dm_wdata`, `dm_be`; set `dm_req` = 1; clear the counter.
  - Next state ACCESS.
- IDLE, memory op and illegal:
  - Illegal means: half access with `addr[0]` = 1, word access with `addr[1:0]` ≠ 0, or `M_funct3` ∈ {011, 110, 111} (loads) or > 010 (stores).
  - Result: `err_access` pulses for that cycle, no request is issued, `stall` = 0.
  - The instruction retires; `M_dm_rd` = 0 and the store is dropped.
- IDLE, no memory op: `stall` = 0 and `M_dm_rd` = 0.
- ACCESS: `stall` = 1. Request outputs are held stable until the access terminates.
  - `dm_ack` = 1: capture the extended `dm_rdata` (loads), drop `dm_req`, go to DONE.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT_CYCLES`: drop `dm_req`, pulse `err_timeout`, load data = 0, go to DONE.
  - `dm_ack` and timeout in the same cycle: ack wins, no error.
- DONE: `stall` = 0 and `M_dm_rd` holds the captured data. The MA/WB register captures it and the pipeline advances.
  - The op detector is not evaluated in DONE, so the completed instruction is not re-issued.
  - Next state IDLE.
- Store lanes:
  - SB: `dm_be` = 1 << `addr[1:0]`; `dm_wdata` = {4{`M_wd[7:0]`}}.
  - SH: `dm_be` = `addr[1]` ? 1100 : 0011; `dm_wdata` = {2{`M_wd[15:0]`}}.
  - SW: `dm_be` = 1111; `dm_wdata` = `M_wd`.
- Loads: `dm_be` = 1111. The selected byte or half comes from `addr[1:0]`.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes `dm_rdata` through.
- `dm_ack` outside ACCESS is ignored.

## Timing
- Stall cycles per legal access = 2 + W, where W is the number of ACCESS cycles before ack. The minimum is 2 (ack in the first ACCESS cycle).
- Worst case is `TIMEOUT_CYCLES` + 1 stall cycles.
- `dm_req` rises one cycle after detection. It falls on the edge after ack or after timeout.
- `err_access` is combinational in IDLE. `err_timeout` is registered and asserted during the DONE cycle.
- Reset asserted mid-ACCESS: `dm_req` and `stall` drop immediately (asynchronously) and the FSM goes to IDLE. The memory side must abandon the transaction.
- Back-to-back memory ops: the second op is detected in the IDLE cycle after DONE. There is no idle gap beyond DONE.

## Test plan
- LW, addr 0x100, ack in the first ACCESS cycle with rdata 0xDEADBEEF:
  - `stall` high exactly 2 cycles.
  - `dm_be` = 1111, `dm_addr` = 0x100.
  - `M_dm_rd` = 0xDEADBEEF in DONE.
- LB, addr 0x103, rdata 0x80FF0000: `M_dm_rd` = 0xFFFFFF80. Repeat as LBU: `M_dm_rd` = 0x00000080.
- SH, addr 0x202, `M_wd` 0x1234ABCD, ack after 3 wait cycles:
  - `dm_be` = 1100, `dm_wdata` = 0xABCDABCD, `dm_we` = 1.
  - `stall` high 5 cycles; request outputs stable throughout.
- LW, addr 0x101:
  - `err_access` pulses one cycle.
  - `dm_req` never rises, `stall` = 0, `M_dm_rd` = 0.
- `TIMEOUT_CYCLES` = 4, no ack:
  - `dm_req` high 4 cycles, then `err_timeout` pulse.
  - `M_dm_rd` = 0 in DONE; `stall` totals 5 cycles.
- Reset pulled low during the second ACCESS cycle:
  - `dm_req` and `stall` go to 0 asynchronously.
  - After release, a new SW to 0x300 completes normally.
